// File: rtl/spi_master_if.sv
// Command-port and serial-line bundle between the SPI master and its user/slave side.
// The master modport is the SPI master itself; the slave modport is its environment.
interface spi_master_if;
    logic       start;
    logic [1:0] cmd;
    logic [7:0] wr_data;
    logic       MISO;
    logic       SS_n;
    logic       MOSI;
    logic       busy;
    logic       done;
    logic [7:0] rd_data;
    logic       rd_valid;

    modport master (
        input  start, cmd, wr_data, MISO,
        output SS_n, MOSI, busy, done, rd_data, rd_valid
    );

    modport slave (
        output start, cmd, wr_data, MISO,
        input  SS_n, MOSI, busy, done, rd_data, rd_valid
    );
endinterface

// File: rtl/spi_master.sv
// SPI master: shifts {cmd, wr_data} out on MOSI framed by SS_n; read-data frames
// (cmd=11) wait RD_WAIT cycles and then shift a byte in from MISO.
module spi_master #(
    parameter int unsigned RD_WAIT  = 1,
    parameter int unsigned IDLE_GAP = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    spi_master_if.master bus
);
    localparam int unsigned WORD_W = 10;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_SHIFT,
        S_WAIT,
        S_READ,
        S_END
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    gap_q, gap_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [BYTE_W-1:0]   sr_q, sr_d;
    logic [BYTE_W-1:0]   rd_data_q, rd_data_d;
    logic                ss_n_q, ss_n_d;
    logic                mosi_q, mosi_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                rd_valid_q, rd_valid_d;
    logic                is_read;

    assign is_read = (word_q[WORD_W-1 -: 2] == 2'b11);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            gap_q      <= '0;
            word_q     <= '0;
            sr_q       <= '0;
            rd_data_q  <= '0;
            ss_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            word_q     <= word_d;
            sr_q       <= sr_d;
            rd_data_q  <= rd_data_d;
            ss_n_q     <= ss_n_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Next state; output values decoded from the current state and registered
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        word_d     = word_q;
        sr_d       = sr_q;
        rd_data_d  = rd_data_q;
        ss_n_d     = 1'b1;
        mosi_d     = 1'b0;
        busy_d     = (state_q != S_IDLE);
        done_d     = 1'b0;
        rd_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - CNT_W'(1);
                end else if (bus.start) begin
                    word_d  = {bus.cmd, bus.wr_data};
                    busy_d  = 1'b1;
                    state_d = S_SEL;
                end
            end
            S_SEL: begin
                ss_n_d  = 1'b0;
                mosi_d  = word_q[WORD_W-1];
                cnt_d   = CNT_W'(WORD_W - 1);
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                ss_n_d = 1'b0;
                mosi_d = word_q[cnt_q];
                if (cnt_q == '0) begin
                    if (is_read) begin
                        cnt_d   = CNT_W'(RD_WAIT - 1);
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_END;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WAIT: begin
                ss_n_d = 1'b0;
                if (cnt_q == '0) begin
                    cnt_d   = CNT_W'(BYTE_W - 1);
                    state_d = S_READ;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_READ: begin
                ss_n_d = 1'b0;
                sr_d   = {sr_q[BYTE_W-2:0], bus.MISO};
                if (cnt_q == '0) begin
                    state_d = S_END;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_END: begin
                done_d     = 1'b1;
                rd_valid_d = is_read;
                if (is_read) begin
                    rd_data_d = sr_q;
                end
                gap_d   = CNT_W'(IDLE_GAP);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.SS_n     = ss_n_q;
    assign bus.MOSI     = mosi_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: frame-level reference model, table vectors, random frames,
// a behavioural SPI RAM slave, and hand sequences for gap and mid-frame reset.
module tb_spi_master;
    localparam int unsigned RD_WAIT  = 1;
    localparam int unsigned IDLE_GAP = 1;

    logic clk = 1'b0;
    logic rst_n;

    spi_master_if bus ();

    spi_master #(.RD_WAIT(RD_WAIT), .IDLE_GAP(IDLE_GAP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] cmd;
        logic [7:0] wr_data;
        logic [7:0] miso_byte;
        bit         pulse_start;
        bit         change_inputs;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_rd_data;
    logic [7:0] slv_ram [256];
    logic [7:0] slv_wr_addr;
    logic [7:0] slv_rd_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.cmd      = 2'b00;
        bus.wr_data  = 8'h00;
        bus.MISO     = 1'b0;
        exp_rd_data  = 8'h00;
        repeat (3) tick();
        check("reset SS_n", 32'(bus.SS_n), 1);
        check("reset MOSI", 32'(bus.MOSI), 0);
        check("reset busy", 32'(bus.busy), 0);
        check("reset done", 32'(bus.done), 0);
        check("reset rd_valid", 32'(bus.rd_valid), 0);
        check("reset rd_data", 32'(bus.rd_data), 0);
        rst_n = 1'b1;
        tick();
    endtask

    // One complete frame, checked cycle by cycle against the expected waveform.
    // Entry requirement: DUT idle with its gap expired.
    task automatic run_frame(input vec_t v, input bit use_slave);
        logic [9:0] word;
        logic [9:0] seen;
        logic [7:0] mb;
        bit         rd;
        int         len;
        int         rd_first;
        word     = {v.cmd, v.wr_data};
        rd       = (v.cmd == 2'b11);
        len      = rd ? 19 + int'(RD_WAIT) : 11;
        rd_first = 12 + int'(RD_WAIT);
        mb       = (use_slave && rd) ? slv_ram[slv_rd_addr] : v.miso_byte;
        seen     = '0;

        bus.start   = 1'b1;
        bus.cmd     = v.cmd;
        bus.wr_data = v.wr_data;
        bus.MISO    = 1'($urandom);
        tick();
        check("busy after accept", 32'(bus.busy), 1);
        bus.start = 1'b0;
        if (v.change_inputs) begin
            bus.cmd     = ~v.cmd;
            bus.wr_data = ~v.wr_data;
        end

        for (int k = 1; k <= len + 1; k++) begin
            logic exp_mosi;
            bus.start = v.pulse_start && (k == 3);
            if (rd && k >= rd_first && k < rd_first + 8)
                bus.MISO = mb[7 - (k - rd_first)];
            else
                bus.MISO = 1'($urandom);
            tick();
            if (k == 1)
                exp_mosi = word[9];
            else if (k <= 11)
                exp_mosi = word[11 - k];
            else
                exp_mosi = 1'b0;
            if (k >= 2 && k <= 11)
                seen[11 - k] = bus.MOSI;
            if (rd && k == len + 1)
                exp_rd_data = mb;
            check($sformatf("SS_n k=%0d", k), 32'(bus.SS_n), (k <= len) ? 0 : 1);
            check($sformatf("MOSI k=%0d", k), 32'(bus.MOSI), 32'(exp_mosi));
            check($sformatf("busy k=%0d", k), 32'(bus.busy), 1);
            check($sformatf("done k=%0d", k), 32'(bus.done), (k == len + 1) ? 1 : 0);
            check($sformatf("rd_valid k=%0d", k), 32'(bus.rd_valid), (rd && k == len + 1) ? 1 : 0);
            check($sformatf("rd_data k=%0d", k), 32'(bus.rd_data), 32'(exp_rd_data));
        end

        // Done cycle: optional start pulse must be dropped by the gap
        bus.start = v.pulse_start;
        tick();
        bus.start = 1'b0;
        check("busy after frame", 32'(bus.busy), 0);
        check("SS_n after frame", 32'(bus.SS_n), 1);
        check("done after frame", 32'(bus.done), 0);
        check("rd_valid after frame", 32'(bus.rd_valid), 0);
        if (v.pulse_start) begin
            tick();
            check("start not queued", 32'(bus.busy), 0);
        end

        if (use_slave) begin
            case (seen[9:8])
                2'b00:   slv_wr_addr = seen[7:0];
                2'b01:   slv_ram[slv_wr_addr] = seen[7:0];
                2'b10:   slv_rd_addr = seen[7:0];
                default: ;
            endcase
        end
    endtask

    initial begin
        vec_t vecs [6];
        vec_t slv_seq [4];
        vec_t rv;
        int   busy_low_k;
        int   ss_low_k;
        bit   saw_done;

        for (int i = 0; i < 256; i++) slv_ram[i] = 8'h00;
        slv_wr_addr = 8'h00;
        slv_rd_addr = 8'h00;

        vecs[0] = '{2'b00, 8'h5A, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{2'b11, 8'h3C, 8'hC3, 1'b0, 1'b0};
        vecs[2] = '{2'b01, 8'hFF, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{2'b10, 8'h81, 8'h00, 1'b0, 1'b1};
        vecs[4] = '{2'b11, 8'h00, 8'h5E, 1'b1, 1'b1};
        vecs[5] = '{2'b01, 8'h00, 8'hAA, 1'b0, 1'b0};

        slv_seq[0] = '{2'b00, 8'h10, 8'h00, 1'b0, 1'b0};
        slv_seq[1] = '{2'b01, 8'hA5, 8'h00, 1'b0, 1'b0};
        slv_seq[2] = '{2'b10, 8'h10, 8'h00, 1'b0, 1'b0};
        slv_seq[3] = '{2'b11, 8'h00, 8'h00, 1'b0, 1'b0};

        do_reset();

        for (int i = 0; i < 6; i++) run_frame(vecs[i], 1'b0);
        check("rd_data holds", 32'(bus.rd_data), 32'h5E);

        for (int i = 0; i < 24; i++) begin
            rv.cmd           = 2'($urandom_range(0, 3));
            rv.wr_data       = 8'($urandom);
            rv.miso_byte     = 8'($urandom);
            rv.pulse_start   = 1'($urandom);
            rv.change_inputs = 1'($urandom);
            run_frame(rv, 1'b0);
        end

        for (int i = 0; i < 4; i++) run_frame(slv_seq[i], 1'b1);
        check("slave readback", 32'(bus.rd_data), 32'hA5);

        // start held high from the accepting edge: ignored while busy, taken after the gap
        bus.start   = 1'b1;
        bus.cmd     = 2'b00;
        bus.wr_data = 8'h00;
        tick();
        busy_low_k = -1;
        ss_low_k   = -1;
        for (int k = 1; k <= 60 && ss_low_k < 0; k++) begin
            tick();
            if (busy_low_k < 0 && bus.busy == 1'b0) busy_low_k = k;
            if (busy_low_k > 0 && ss_low_k < 0 && bus.SS_n == 1'b0) ss_low_k = k;
        end
        bus.start = 1'b0;
        check("gap busy low cycle", 32'(busy_low_k), 13);
        check("gap next frame SS_n low", 32'(ss_low_k), 32'(14 + IDLE_GAP));
        saw_done = 1'b0;
        for (int k = 0; k < 40 && !saw_done; k++) begin
            tick();
            if (bus.done) saw_done = 1'b1;
        end
        check("gap second frame done", 32'(saw_done), 1);
        repeat (IDLE_GAP + 1) tick();

        // Reset in the 5th SHIFT cycle of a read-data frame
        bus.start   = 1'b1;
        bus.cmd     = 2'b11;
        bus.wr_data = 8'h42;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        check("midframe SS_n low", 32'(bus.SS_n), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async SS_n", 32'(bus.SS_n), 1);
        check("async busy", 32'(bus.busy), 0);
        check("async done", 32'(bus.done), 0);
        check("async rd_valid", 32'(bus.rd_valid), 0);
        check("async rd_data", 32'(bus.rd_data), 0);
        exp_rd_data = 8'h00;
        tick();
        rst_n = 1'b1;
        rv = '{2'b11, 8'h77, 8'h96, 1'b0, 1'b0};
        run_frame(rv, 1'b0);
        check("post-reset rd_data", 32'(bus.rd_data), 32'h96);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Single-clock SPI master that drives the SPI slave/RAM subsystem from a parallel command port.
- Serialises a 10-bit command word {cmd[1:0], wr_data[7:0]} onto MOSI, MSB first, framed by SS_n.
- For read-data commands (cmd=2'b11), it waits a fixed turnaround, then shifts 8 bits in from MISO and presents them on rd_data.
- Sits between the system controller (or testbench stimulus) and the slave, on the same clock as the slave.

Parameters:
- RD_WAIT, 1: idle cycles between the last MOSI bit and the first MISO sample on a read-data frame. Legal range 1..15.
- IDLE_GAP, 1: minimum cycles SS_n stays high after a frame before the next start is accepted. Legal range 1..15.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a transaction; sampled only in IDLE.
- cmd  in  2  command: 00 write-address, 01 write-data, 10 read-address, 11 read-data.
- wr_data  in  8  address/data byte sent after cmd.
- MISO  in  1  serial data from slave.
- SS_n  out  1  active-low slave select.
- MOSI  out  1  serial data to slave.
- busy  out  1  high from the cycle after start is accepted until return to IDLE.
- done  out  1  one-cycle pulse at frame end.
- rd_data  out  8  byte received on the last read-data frame; holds until the next read-data frame completes.
- rd_valid  out  1  one-cycle pulse, coincident with done, on read-data frames only.

Behaviour:
- All outputs are registered. Async reset forces: SS_n=1, MOSI=0, busy=0, done=0, rd_valid=0, rd_data=8'h00, state=IDLE, all counters=0.
- start, cmd and wr_data are captured into a shadow register on the accepting edge (E0). Later changes to the inputs do not affect the frame in flight.
- States:
  - IDLE: SS_n=1. If start=1 and the gap counter has expired, capture inputs and go to SEL.
  - SEL: 1 cycle. SS_n=0, MOSI=cmd[1] (read/write select bit).
  - SHIFT: 10 cycles. MOSI=word[9] down to word[0], where word={cmd,wr_data}; 4-bit down counter.
  - After SHIFT: go to WAIT if cmd==11, otherwise go to END.
  - WAIT: RD_WAIT cycles. SS_n=0, MOSI=0.
  - READ: 8 cycles. MISO is sampled each rising edge into a shift register, MSB first.
  - END: 1 cycle. SS_n=1, MOSI=0, done=1. On read-data frames, rd_data is loaded and rd_valid=1. The gap counter is loaded with IDLE_GAP, then the machine goes to IDLE.
- Timing for a write frame: SS_n is low for exactly 11 cycles (outputs after E1..E11); done is high after E12.
- Timing for a read-data frame: SS_n is low for 11+RD_WAIT+8 cycles; done and rd_valid are high 20+RD_WAIT cycles after E0.
- busy stays high through END; it is low only in IDLE.
- start while busy, or during the gap, is ignored (not queued).
- Illegal encodings do not exist: all four cmd values are valid. Only cmd==11 reads MISO.
- Reset asserted mid-frame: SS_n=1 immediately (asynchronous), no done pulse, rd_data=0.
- MISO is ignored outside READ.

Test Plan:
- Reset, then start with cmd=00, wr_data=8'h5A.
  -> MOSI bits across the 11 SS_n-low cycles = 0, 0,0,0,1,0,1,1,0,1,0. SS_n high and done=1 in cycle 12. rd_valid stays 0.
- cmd=11 with a MISO model driving 8'hC3 MSB first after RD_WAIT=1.
  -> SS_n low for 20 cycles. rd_data=8'hC3 with rd_valid=done=1 for one cycle, 21 cycles after E0. rd_data holds 8'hC3 afterwards.
- Connect to spi_slave plus RAM: write address 8'h10, write data 8'hA5, read address 8'h10, read data.
  -> rd_data=8'hA5.
- Pulse start three cycles into a frame, and again during the done cycle.
  -> Both ignored. Next frame begins only after IDLE_GAP cycles with SS_n=1.
- Change cmd/wr_data on the cycle after E0.
  -> MOSI still shows the captured word.
- Assert rst_n=0 at the 5th SHIFT cycle.
  -> SS_n=1, busy=0, done=0, rd_data=0 immediately. A new start after release runs a normal frame.
